// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and constants for the serial multi-byte add/subtract engine.
// Holds the FSM encoding, the byte width and the index-width helper.
package serial_add_sequencer_pkg;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a byte index able to address 0..n-1 (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W_DEF = idx_width(NBYTES_DEF);

endpackage

// File: rtl/serial_add_sequencer_adder.sv
// Shared 8-bit ripple-carry adder used as the serial datapath.
// Ports: a_i, b_i, cin_i in; sum_o, cout_o out.
module serial_add_sequencer_adder
  import serial_add_sequencer_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              cout_o
);

  logic [BYTE_W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i])
                    | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[BYTE_W];

endmodule

// File: rtl/serial_add_sequencer.sv
// Multi-byte add/subtract sequencer, one byte per cycle, LSB first.
// Ports: clk, rst_n, start, sub, a, b, cin in; busy, done, sum, cout, overflow out.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sub,
  input  logic [8*NBYTES-1:0]      a,
  input  logic [8*NBYTES-1:0]      b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [8*NBYTES-1:0]      sum,
  output logic                     cout,
  output logic                     overflow
);

  localparam int W     = NBYTES * BYTE_W;
  localparam int IDX_W = idx_width(NBYTES);

  state_e            state_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic [W-1:0]      sum_d;
  logic              sub_q;
  logic              carry_q;
  logic [IDX_W-1:0]  idx_q;
  logic              busy_q;
  logic              done_q;
  logic              cout_q;
  logic              ovf_q;

  logic [BYTE_W-1:0] add_a;
  logic [BYTE_W-1:0] add_b;
  logic [BYTE_W-1:0] add_s;
  logic              add_co;
  logic              last;
  logic              ovf_d;

  // Operands shift right each RUN cycle, so byte 0 always feeds the adder.
  assign add_a = a_q[BYTE_W-1:0];
  assign add_b = sub_q ? ~b_q[BYTE_W-1:0]
                       :  b_q[BYTE_W-1:0];
  assign last  = (idx_q == IDX_W'(NBYTES - 1));

  // Only meaningful on the last byte, where bit 7 is the result MSB.
  assign ovf_d = (add_a[BYTE_W-1] == add_b[BYTE_W-1])
              && (add_s[BYTE_W-1] != add_a[BYTE_W-1]);

  serial_add_sequencer_adder u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_s),
    .cout_o (add_co)
  );

  always_comb begin
    sum_d = sum_q;
    sum_d[int'(idx_q) * BYTE_W +: BYTE_W] = add_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            // Subtract is a + ~b + 1, so the +1 rides in on the carry.
            carry_q <= sub | cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> BYTE_W;
          b_q     <= b_q >> BYTE_W;
          sum_q   <= sum_d;
          carry_q <= add_co;
          cout_q  <= add_co;
          ovf_q   <= ovf_d;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (NBYTES=4).
// Vector table plus handshake/reset sequences, scoreboard on done.
module tb_serial_add_sequencer;

  localparam int NB = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic [31:0]   a;
  logic [31:0]   b;
  logic          cin;
  logic          busy;
  logic          done;
  logic [31:0]   sum;
  logic          cout;
  logic          overflow;

  serial_add_sequencer #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } sb_t;

  sb_t sbq[$];
  int  ncmp  = 0;
  int  nfail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: full 32-bit arithmetic, independent of byte slicing.
  function automatic sb_t model(input logic [31:0] x,
                                input logic [31:0] y,
                                input logic s,
                                input logic ci);
    sb_t r;
    logic [31:0] be;
    logic [32:0] t;
    be = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, be} + 33'(s ? 1'b1 : ci);
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (x[31] == be[31]) && (t[31] != x[31]);
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("sum", 64'(sum), 64'(e.sum));
        check("cout", 64'(cout), 64'(e.cout));
        check("ovf", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) return;
    end
    ncmp++;
    nfail++;
    $display("FAIL done_timeout: got no done want done within 50");
  endtask

  task automatic push(input logic [31:0] s,
                      input logic c,
                      input logic o);
    sb_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    sbq.push_back(e);
  endtask

  task automatic run_one(input vec_t v, input string nm);
    int cyc;
    int bcnt;
    push(v.esum, v.ecout, v.eovf);
    a     = v.a;
    b     = v.b;
    sub   = v.sub;
    cin   = v.cin;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcnt);
    check({nm, "_lat"}, 64'(cyc), 64'(NB + 1));
    check({nm, "_busy"}, 64'(bcnt), 64'(NB));
  endtask

  vec_t vt[13];

  initial begin
    sb_t m;
    int  cyc;
    int  bcnt;
    realtime t1;
    realtime t2;

    vt[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0,
              32'h00000100, 1'b0, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0,
              32'h00000000, 1'b1, 1'b0};
    vt[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1,
              32'h00000000, 1'b1, 1'b0};
    vt[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0,
              32'hFFFFFFFE, 1'b0, 1'b0};
    vt[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0,
              32'h7FFFFFFF, 1'b1, 1'b1};
    vt[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
              32'h80000000, 1'b0, 1'b1};
    vt[6] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0,
              32'hACF13568, 1'b0, 1'b0};
    vt[7] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1,
              32'h00000007, 1'b1, 1'b0};
    vt[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0,
              32'h00000000, 1'b1, 1'b1};
    for (int i = 9; i < 13; i++) begin
      vt[i].a   = $urandom;
      vt[i].b   = $urandom;
      vt[i].sub = 1'($urandom_range(0, 1));
      vt[i].cin = 1'($urandom_range(0, 1));
      m = model(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin);
      vt[i].esum  = m.sum;
      vt[i].ecout = m.cout;
      vt[i].eovf  = m.ovf;
    end

    rst_n = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      run_one(vt[i], $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
    end

    // start re-pulsed mid-RUN with new operands: ignored, not queued.
    push(32'h33333333, 1'b0, 1'b0);
    a = 32'h11111111; b = 32'h22222222;
    sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    a = 32'hDEADBEEF; b = 32'h01020304;
    sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcnt);
    repeat (8) @(posedge clk);
    #1;

    // start held high through done: back-to-back, operands swapped mid-RUN.
    push(32'h00010000, 1'b0, 1'b0);
    a = 32'h0000FFFF; b = 32'h00000001;
    sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    m = model(32'h00000010, 32'h00000020, 1'b1, 1'b0);
    push(m.sum, m.cout, m.ovf);
    a = 32'h00000010; b = 32'h00000020; sub = 1'b1;
    wait_done(cyc, bcnt);
    t1 = $realtime;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcnt);
    t2 = $realtime;
    check("b2b_gap", 64'(int'((t2 - t1) / 10.0)), 64'd5);
    @(posedge clk);
    #1;

    // Async reset in the second RUN cycle: everything clears, no done.
    a = 32'h01010101; b = 32'h01010101;
    sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    check("post_rst_idle_busy", 64'(busy), 64'd0);
    #1;
    run_one('{32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0},
            "after_rst");
    repeat (3) @(posedge clk);

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
